// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared definitions for the processor bus register file.
//               Bus source codes are laid out as NREGS general registers
//               followed by four special sources. The constants below are
//               offsets from NREGS. The package also holds the immediate
//               format enum and the source-select width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

   // Special source codes, as offsets above the last general register
   localparam int C_SRC_G_OFS       = 0;   // G accumulator
   localparam int C_SRC_D_OFS       = 1;   // zero-extended immediate
   localparam int C_SRC_DT_OFS      = 2;   // low half of IR moved to top half
   localparam int C_SRC_DS_OFS      = 3;   // sign-extended immediate
   localparam int C_SRC_SPECIAL_CNT = 4;

   // Immediate formats produced from the instruction register
   typedef enum logic [1:0] {
      IMM_D  = 2'd0,
      IMM_DT = 2'd1,
      IMM_DS = 2'd2
   } imm_fmt_e;

   // Width of a source select that can encode every register and special code
   function automatic int sel_width(input int nregs);
      return $clog2(nregs + C_SRC_SPECIAL_CNT);
   endfunction

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_regfile_imm_format.sv
`default_nettype none
// ============================================================================
// Module      : imm_format
// Description : Combinational immediate generator. Builds one of the three
//               IR-derived bus operands:
//                 D  : ir[IMMW-1:0] zero-extended to WIDTH
//                 DT : {ir[WIDTH/2-1:0], WIDTH/2 zeros}
//                 DS : ir[IMMW-1:0] sign-extended to WIDTH
// Ports       : i_fmt - format select (imm_fmt_e)
//               i_ir  - instruction register contents
//               o_imm - formatted immediate
// Revision    : 1.0 - initial release
// ============================================================================
module imm_format
   import bus_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int IMMW  = 9
) (
   input  imm_fmt_e         i_fmt,
   input  logic [WIDTH-1:0] i_ir,
   output logic [WIDTH-1:0] o_imm
);

   if (IMMW > WIDTH) begin : g_bad_immw
      $error("imm_format: IMMW must not exceed WIDTH");
   end
   if ((WIDTH % 2) != 0) begin : g_bad_width
      $error("imm_format: WIDTH must be even");
   end

   // Depending on IMMW, some IR bits feed none of the formats
   logic w_unused_ir;
   assign w_unused_ir = ^i_ir;

   always_comb begin
      o_imm = '0;
      case (i_fmt)
         IMM_D: begin
            // Field assignment keeps IMMW == WIDTH legal (no zero-width pad)
            o_imm[IMMW-1:0] = i_ir[IMMW-1:0];
         end
         IMM_DT: begin
            o_imm = {i_ir[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         end
         IMM_DS: begin
            o_imm           = {WIDTH{i_ir[IMMW-1]}};
            o_imm[IMMW-1:0] = i_ir[IMMW-1:0];
         end
         default: o_imm = '0;
      endcase
   end

endmodule : imm_format
`default_nettype wire

// File: rtl/bus_regfile.sv
`default_nettype none
// ============================================================================
// Module      : bus_regfile
// Description : NREGS-entry register file with a registered multi-source
//               processor bus. One cycle after a valid request, o_bus_out
//               holds the selected register, G, or an IR immediate. A write
//               stores the current o_bus_out into register i_wr_sel.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_src_valid   - bus transfer request
//               i_src_sel     - source code (regs, G, D, DT, DS)
//               i_wr_en       - write o_bus_out into register i_wr_sel
//               i_wr_sel      - destination register index
//               i_ir_in       - instruction register
//               i_g_in        - G accumulator
//               i_err_clr     - clear o_sel_err
//               o_bus_out     - registered bus value
//               o_bus_valid   - o_bus_out loaded by the previous transfer
//               o_sel_err     - sticky invalid-source flag
// Revision    : 1.0 - initial release
// ============================================================================
module bus_regfile
   import bus_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   parameter int IMMW  = 9,
   parameter int SELW  = sel_width(NREGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_src_valid,
   input  logic [SELW-1:0]          i_src_sel,
   input  logic                     i_wr_en,
   input  logic [$clog2(NREGS)-1:0] i_wr_sel,
   input  logic [WIDTH-1:0]         i_ir_in,
   input  logic [WIDTH-1:0]         i_g_in,
   input  logic                     i_err_clr,
   output logic [WIDTH-1:0]         o_bus_out,
   output logic                     o_bus_valid,
   output logic                     o_sel_err
);

   localparam int RIDXW = $clog2(NREGS);

   if (NREGS < 2) begin : g_bad_nregs
      $error("bus_regfile: NREGS must be at least 2");
   end

   // Source codes at select width; SELW always has room for NREGS+3
   localparam logic [SELW-1:0]  C_SEL_NREGS = SELW'(NREGS);
   localparam logic [SELW-1:0]  C_SEL_G     = SELW'(NREGS + C_SRC_G_OFS);
   localparam logic [SELW-1:0]  C_SEL_D     = SELW'(NREGS + C_SRC_D_OFS);
   localparam logic [SELW-1:0]  C_SEL_DT    = SELW'(NREGS + C_SRC_DT_OFS);
   localparam logic [SELW-1:0]  C_SEL_DS    = SELW'(NREGS + C_SRC_DS_OFS);
   // One extra bit so the bound is representable when NREGS is a power of 2
   localparam logic [RIDXW:0]   C_WR_LIMIT  = NREGS[RIDXW:0];

   logic [WIDTH-1:0] r_regs [NREGS];
   logic [WIDTH-1:0] r_bus;
   logic             r_bus_valid;
   logic             r_sel_err;

   logic [RIDXW-1:0] w_rd_idx;
   logic             w_is_reg;
   logic             w_wr_ok;
   logic             w_bypass;
   logic             w_code_ok;
   logic             w_xfer;
   logic             w_bad_req;
   imm_fmt_e         w_fmt;
   logic [WIDTH-1:0] w_imm;
   logic [WIDTH-1:0] w_src;

   assign w_rd_idx = i_src_sel[RIDXW-1:0];
   assign w_is_reg = (i_src_sel < C_SEL_NREGS);
   // Out-of-range write indices are silently dropped
   assign w_wr_ok  = ({1'b0, i_wr_sel} < C_WR_LIMIT);

   // A read of the register being written this cycle sees the written data,
   // which is the current bus value
   assign w_bypass = i_wr_en && w_wr_ok && w_is_reg && (i_wr_sel == w_rd_idx);

   always_comb begin
      w_fmt = IMM_D;
      if (i_src_sel == C_SEL_DT) begin
         w_fmt = IMM_DT;
      end else if (i_src_sel == C_SEL_DS) begin
         w_fmt = IMM_DS;
      end
   end

   imm_format #(
      .WIDTH (WIDTH),
      .IMMW  (IMMW)
   ) u_imm_format (
      .i_fmt (w_fmt),
      .i_ir  (i_ir_in),
      .o_imm (w_imm)
   );

   // Source mux; w_code_ok drops for codes above DS
   always_comb begin
      w_src     = '0;
      w_code_ok = 1'b1;
      if (w_is_reg) begin
         w_src = w_bypass ? r_bus : r_regs[w_rd_idx];
      end else if (i_src_sel == C_SEL_G) begin
         w_src = i_g_in;
      end else if ((i_src_sel == C_SEL_D) || (i_src_sel == C_SEL_DT) ||
                   (i_src_sel == C_SEL_DS)) begin
         w_src = w_imm;
      end else begin
         w_code_ok = 1'b0;
      end
   end

   assign w_xfer    = i_src_valid &&  w_code_ok;
   assign w_bad_req = i_src_valid && !w_code_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NREGS; k++) begin
            r_regs[k] <= '0;
         end
         r_bus       <= '0;
         r_bus_valid <= 1'b0;
         r_sel_err   <= 1'b0;
      end else begin
         if (i_wr_en && w_wr_ok) begin
            r_regs[i_wr_sel] <= r_bus;
         end
         r_bus_valid <= w_xfer;
         if (w_xfer) begin
            r_bus <= w_src;
         end
         // Setting has priority over clearing in the same cycle
         if (w_bad_req) begin
            r_sel_err <= 1'b1;
         end else if (i_err_clr) begin
            r_sel_err <= 1'b0;
         end
      end
   end

   assign o_bus_out   = r_bus;
   assign o_bus_valid = r_bus_valid;
   assign o_sel_err   = r_sel_err;

endmodule : bus_regfile
`default_nettype wire

// File: tb/tb_bus_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_regfile
// Description : Self-checking bench for bus_regfile. The main instance
//               (WIDTH=16, NREGS=8, IMMW=9) is compared with a behavioural
//               model of the bus and register contents. A second instance
//               (WIDTH=32, NREGS=5, IMMW=12) gets directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   // Main instance
   logic        src_valid, wr_en, err_clr;
   logic [3:0]  src_sel;
   logic [2:0]  wr_sel;
   logic [15:0] ir_in, g_in;
   logic [15:0] bus_out;
   logic        bus_valid, sel_err;

   // Second instance
   logic        c2_src_valid, c2_wr_en, c2_err_clr;
   logic [3:0]  c2_src_sel;
   logic [2:0]  c2_wr_sel;
   logic [31:0] c2_ir_in, c2_g_in;
   logic [31:0] c2_bus_out;
   logic        c2_bus_valid, c2_sel_err;

   // Behavioural model state
   logic [15:0] m_regs [8];
   logic [15:0] m_bus;
   logic        m_valid, m_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bus_regfile #(.WIDTH(16), .NREGS(8), .IMMW(9)) dut (
      .clk(clk), .rst(rst),
      .i_src_valid(src_valid), .i_src_sel(src_sel),
      .i_wr_en(wr_en), .i_wr_sel(wr_sel),
      .i_ir_in(ir_in), .i_g_in(g_in), .i_err_clr(err_clr),
      .o_bus_out(bus_out), .o_bus_valid(bus_valid), .o_sel_err(sel_err)
   );

   bus_regfile #(.WIDTH(32), .NREGS(5), .IMMW(12)) dut2 (
      .clk(clk), .rst(rst),
      .i_src_valid(c2_src_valid), .i_src_sel(c2_src_sel),
      .i_wr_en(c2_wr_en), .i_wr_sel(c2_wr_sel),
      .i_ir_in(c2_ir_in), .i_g_in(c2_g_in), .i_err_clr(c2_err_clr),
      .o_bus_out(c2_bus_out), .o_bus_valid(c2_bus_valid), .o_sel_err(c2_sel_err)
   );

   task automatic model_reset();
      for (int k = 0; k < 8; k++) m_regs[k] = '0;
      m_bus   = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
   endtask

   // Next state from the source-code table using plain arithmetic
   task automatic model_step();
      int          s;
      int          d;
      logic [15:0] val;
      logic        ok;
      s   = int'(src_sel);
      d   = int'(ir_in) % 512;
      ok  = 1'b1;
      val = m_bus;
      if (s < 8)        val = (wr_en && int'(wr_sel) == s) ? m_bus : m_regs[s];
      else if (s == 8)  val = g_in;
      else if (s == 9)  val = 16'(d);
      else if (s == 10) val = 16'((int'(ir_in) % 256) * 256);
      else if (s == 11) val = (d >= 256) ? 16'(d + 65536 - 512) : 16'(d);
      else              ok  = 1'b0;
      if (wr_en) m_regs[wr_sel] = m_bus;
      if (src_valid && ok) m_bus = val;
      m_valid = src_valid && ok;
      if (src_valid && !ok) m_err = 1'b1;
      else if (err_clr)     m_err = 1'b0;
   endtask

   // Apply one cycle of main-instance inputs, advance model, move past the edge
   task automatic drive(input logic v, input int s, input logic w, input int ws,
                        input logic [15:0] ir, input logic [15:0] g, input logic clr);
      src_valid = v;
      src_sel   = 4'(s);
      wr_en     = w;
      wr_sel    = 3'(ws);
      ir_in     = ir;
      g_in      = g;
      err_clr   = clr;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      src_valid = 1'b1; src_sel = 4'd8; wr_en = 1'b1; wr_sel = 3'd1;
      ir_in = 16'hFFFF; g_in = 16'hFFFF; err_clr = 1'b1;
      #1 rst = 1'b1;
      #1;
      n_checks++; if (bus_out !== 16'h0) begin n_errors++; $display("FAIL reset_bus actual=%h expected=0000", bus_out); end
      n_checks++; if (bus_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid actual=%b expected=0", bus_valid); end
      n_checks++; if (sel_err !== 1'b0) begin n_errors++; $display("FAIL reset_err actual=%b expected=0", sel_err); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 0, 1'b0, 0, 16'h0, 16'h0, 1'b0);
         n_checks++;
         if (bus_out !== 16'h0 || bus_valid !== 1'b0 || sel_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle cyc=%0d actual bus=%h valid=%b err=%b expected 0000/0/0",
                     i, bus_out, bus_valid, sel_err);
         end
      end
   endtask

   task automatic test_imm_formats();
      int          codes [3] = '{9, 11, 10};
      logic [15:0] irs   [3] = '{16'h01A5, 16'h0180, 16'h00C3};
      logic [15:0] exps  [3] = '{16'h01A5, 16'hFF80, 16'hC300};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, codes[i], 1'b0, 0, irs[i], 16'h0, 1'b0);
         n_checks++;
         if (bus_out !== exps[i] || bus_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL imm_xfer code=%0d actual=%h/%b expected=%h/1", codes[i], bus_out, bus_valid, exps[i]);
         end
         drive(1'b0, 0, 1'b1, 3, 16'h0, 16'h0, 1'b0);
         n_checks++;
         if (bus_out !== exps[i] || bus_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL imm_hold code=%0d actual=%h/%b expected=%h/0", codes[i], bus_out, bus_valid, exps[i]);
         end
         drive(1'b1, 0, 1'b0, 0, 16'h0, 16'h0, 1'b0);   // clobber the bus with R0
         drive(1'b1, 3, 1'b0, 0, 16'h0, 16'h0, 1'b0);
         n_checks++;
         if (bus_out !== exps[i] || bus_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL imm_readback_r3 code=%0d actual=%h expected=%h", codes[i], bus_out, exps[i]);
         end
      end
   endtask

   task automatic test_collision();
      drive(1'b1, 8, 1'b0, 0, 16'h0, 16'h1234, 1'b0);
      drive(1'b0, 0, 1'b1, 1, 16'h0, 16'h0, 1'b0);       // R1 = 1234
      // Bus loads G while R1 is written with the old bus value
      drive(1'b1, 8, 1'b1, 1, 16'h0, 16'hBEEF, 1'b0);
      n_checks++; if (bus_out !== 16'hBEEF) begin n_errors++; $display("FAIL coll_g actual=%h expected=beef", bus_out); end
      drive(1'b1, 1, 1'b0, 0, 16'h0, 16'h0, 1'b0);
      n_checks++; if (bus_out !== 16'h1234) begin n_errors++; $display("FAIL coll_r1_old actual=%h expected=1234", bus_out); end
      drive(1'b1, 8, 1'b0, 0, 16'h0, 16'hBEEF, 1'b0);
      // Read and write R1 in the same cycle: bus takes the value being written
      drive(1'b1, 1, 1'b1, 1, 16'h0, 16'h0, 1'b0);
      n_checks++; if (bus_out !== 16'hBEEF) begin n_errors++; $display("FAIL coll_bypass actual=%h expected=beef", bus_out); end
      drive(1'b1, 0, 1'b0, 0, 16'h0, 16'h0, 1'b0);
      drive(1'b1, 1, 1'b0, 0, 16'h0, 16'h0, 1'b0);
      n_checks++; if (bus_out !== 16'hBEEF) begin n_errors++; $display("FAIL coll_r1_new actual=%h expected=beef", bus_out); end
   endtask

   task automatic test_sel_err();
      drive(1'b1, 8, 1'b0, 0, 16'h0, 16'h5555, 1'b0);
      drive(1'b1, 13, 1'b0, 0, 16'h0, 16'h0, 1'b0);
      n_checks++;
      if (bus_out !== 16'h5555 || bus_valid !== 1'b0 || sel_err !== 1'b1) begin
         n_errors++;
         $display("FAIL err_set actual bus=%h valid=%b err=%b expected 5555/0/1", bus_out, bus_valid, sel_err);
      end
      drive(1'b0, 0, 1'b0, 0, 16'h0, 16'h0, 1'b1);
      n_checks++; if (sel_err !== 1'b0) begin n_errors++; $display("FAIL err_clear actual=%b expected=0", sel_err); end
      drive(1'b0, 14, 1'b0, 0, 16'h0, 16'h0, 1'b0);       // invalid code without a request
      n_checks++; if (sel_err !== 1'b0) begin n_errors++; $display("FAIL err_no_req actual=%b expected=0", sel_err); end
      drive(1'b1, 15, 1'b0, 0, 16'h0, 16'h0, 1'b1);
      n_checks++; if (sel_err !== 1'b1) begin n_errors++; $display("FAIL err_set_wins actual=%b expected=1", sel_err); end
      n_checks++; if (bus_out !== 16'h5555) begin n_errors++; $display("FAIL err_hold actual=%h expected=5555", bus_out); end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 8, 1'b0, 0, 16'h0, 16'hAAAA, 1'b0);
      drive(1'b0, 0, 1'b1, 2, 16'h0, 16'h0, 1'b0);
      drive(1'b1, 2, 1'b0, 0, 16'h0, 16'h0, 1'b0);
      n_checks++; if (bus_out !== 16'hAAAA) begin n_errors++; $display("FAIL rmid_r2_loaded actual=%h expected=aaaa", bus_out); end
      src_valid = 1'b1; src_sel = 4'd2; wr_en = 1'b1; wr_sel = 3'd2; err_clr = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus_out !== 16'h0 || bus_valid !== 1'b0 || sel_err !== 1'b0) begin
         n_errors++;
         $display("FAIL rmid_async actual bus=%h valid=%b err=%b expected 0000/0/0", bus_out, bus_valid, sel_err);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive(1'b1, 2, 1'b0, 0, 16'h0, 16'h0, 1'b0);
      n_checks++;
      if (bus_out !== 16'h0 || bus_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL rmid_after actual=%h/%b expected=0000/1", bus_out, bus_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
               ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
               16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));
         n_checks++;
         if (bus_out !== m_bus || bus_valid !== m_valid || sel_err !== m_err) begin
            n_errors++;
            $display("FAIL random cyc=%0d actual bus=%h valid=%b err=%b expected %h/%b/%b",
                     i, bus_out, bus_valid, sel_err, m_bus, m_valid, m_err);
         end
      end
   endtask

   task automatic test_cfg2();
      // NREGS=5: G=5, D=6, DT=7, DS=8, 9 and above invalid
      c2_src_valid = 1'b1; c2_src_sel = 4'd6; c2_ir_in = 32'h00000FFF;
      drive(1'b0, 0, 1'b0, 0, 16'h0, 16'h0, 1'b0);
      n_checks++; if (c2_bus_out !== 32'h00000FFF || c2_bus_valid !== 1'b1) begin n_errors++; $display("FAIL c2_d actual=%h expected=00000fff", c2_bus_out); end
      c2_src_sel = 4'd8;
      drive(1'b0, 0, 1'b0, 0, 16'h0, 16'h0, 1'b0);
      n_checks++; if (c2_bus_out !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL c2_ds actual=%h expected=ffffffff", c2_bus_out); end
      c2_src_sel = 4'd7; c2_ir_in = 32'h0000ABCD;
      drive(1'b0, 0, 1'b0, 0, 16'h0, 16'h0, 1'b0);
      n_checks++; if (c2_bus_out !== 32'hABCD0000) begin n_errors++; $display("FAIL c2_dt actual=%h expected=abcd0000", c2_bus_out); end
      c2_src_valid = 1'b0; c2_wr_en = 1'b1; c2_wr_sel = 3'd6;
      drive(1'b0, 0, 1'b0, 0, 16'h0, 16'h0, 1'b0);
      c2_wr_en = 1'b0;
      n_checks++; if (c2_sel_err !== 1'b0 || c2_bus_valid !== 1'b0) begin n_errors++; $display("FAIL c2_wr6 actual err=%b valid=%b expected 0/0", c2_sel_err, c2_bus_valid); end
      for (int k = 0; k < 5; k++) begin
         c2_src_valid = 1'b1; c2_src_sel = 4'(k);
         drive(1'b0, 0, 1'b0, 0, 16'h0, 16'h0, 1'b0);
         n_checks++; if (c2_bus_out !== 32'h0) begin n_errors++; $display("FAIL c2_reg%0d actual=%h expected=00000000", k, c2_bus_out); end
      end
      c2_src_sel = 4'd9;
      drive(1'b0, 0, 1'b0, 0, 16'h0, 16'h0, 1'b0);
      c2_src_valid = 1'b0;
      n_checks++;
      if (c2_sel_err !== 1'b1 || c2_bus_valid !== 1'b0 || c2_bus_out !== 32'h0) begin
         n_errors++;
         $display("FAIL c2_code9 actual err=%b valid=%b bus=%h expected 1/0/00000000", c2_sel_err, c2_bus_valid, c2_bus_out);
      end
   endtask

   initial begin
      src_valid = 1'b0; src_sel = '0; wr_en = 1'b0; wr_sel = '0;
      ir_in = '0; g_in = '0; err_clr = 1'b0;
      c2_src_valid = 1'b0; c2_src_sel = '0; c2_wr_en = 1'b0; c2_wr_sel = '0;
      c2_ir_in = '0; c2_g_in = '0; c2_err_clr = 1'b0;
      model_reset();
      test_reset();
      test_imm_formats();
      test_collision();
      test_sel_err();
      test_reset_mid();
      test_random();
      test_cfg2();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_bus_regfile
`default_nettype wire

// File: doc/bus_regfile.md
# bus_regfile

Parametrised register file with a registered, multi-source processor bus for the simple processor datapath. Holds NREGS general registers, drives a one-cycle-latency bus from a register, the G accumulator or one of three IR immediate formats, and writes the bus back into a selected register. It sits between the control FSM, which drives the selects and enables, and the ALU, which consumes `bus_out` and produces `g_in`.

## Interface
- `WIDTH`, 16, data width; must be even.
- `NREGS`, 8, number of general registers; must be at least 2.
- `IMMW`, 9, immediate field width in IR; must satisfy IMMW ≤ WIDTH.
- `SELW`, $clog2(NREGS+4), derived select width; never overridden.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `src_valid`  in  1  bus transfer request this cycle.
- `src_sel`  in  SELW  bus source code.
- `wr_en`  in  1  write current `bus_out` into register `wr_sel`.
- `wr_sel`  in  $clog2(NREGS)  destination register index.
- `ir_in`  in  WIDTH  instruction register contents.
- `g_in`  in  WIDTH  G accumulator value from the ALU.
- `err_clr`  in  1  clears `sel_err`.
- `bus_out`  out  WIDTH  registered bus value.
- `bus_valid`  out  1  `bus_out` was loaded by the previous cycle's transfer.
- `sel_err`  out  1  sticky flag for an invalid source code.

## Operation
- Source codes:
  - 0..NREGS-1: register Rk.
  - NREGS: G.
  - NREGS+1: D, zero-extended `ir_in[IMMW-1:0]`.
  - NREGS+2: DT, `{ir_in[WIDTH/2-1:0], WIDTH/2 zeros}`.
  - NREGS+3: DS, sign-extended `ir_in[IMMW-1:0]`.
  - All higher codes are invalid.
- Valid transfer (`src_valid`=1, legal code): `bus_out` loads the selected value at the next edge and `bus_valid`=1 for that cycle.
- Invalid code with `src_valid`=1: `bus_out` holds, `bus_valid`=0, `sel_err` sets.
- `src_valid`=0: `bus_out` holds and `bus_valid`=0.
- Write: when `wr_en`=1, register `wr_sel` takes the current `bus_out` at the edge. A `wr_sel` ≥ NREGS is ignored and does not set `sel_err`.
- Read/write collision: if a transfer selects Rk in the same cycle that `wr_en` writes Rk, the bus loads the value being written (the current `bus_out`), not the stale Rk.
- Register-to-register move Rx→Ry takes 2 cycles:
  - Cycle t: `src_sel`=x, `src_valid`=1.
  - Cycle t+1: `wr_en`=1, `wr_sel`=y.
- `sel_err`: set on an invalid request, cleared by `err_clr` or `rst`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert): all registers 0, `bus_out`=0, `bus_valid`=0, `sel_err`=0.
- Reset asserted mid-transfer discards the transfer. The first request after release behaves normally.
- Bus latency: exactly 1 cycle from the `src_valid` sample to `bus_out`/`bus_valid`.
- Write latency: register updated at the sampling edge, readable by a transfer issued in the next cycle. Same-cycle reads are covered by the collision rule.
- Back-to-back transfers are legal every cycle; there is no backpressure.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `bus_pkg`:
  - Source-code constants expressed relative to NREGS (SRC_G, SRC_D, SRC_DT, SRC_DS offsets).
  - Immediate-format enum.
  - The SELW derivation function.
- One sub-module, `imm_format`: combinational generator of the D/DT/DS values from `ir_in`, parametrised by WIDTH and IMMW.
- The top level holds the register array, the source mux, the collision bypass, the bus register and the error flag.

## Test plan
- Reset with all inputs active, release, idle 3 cycles → `bus_out`=0, `bus_valid`=0, `sel_err`=0 throughout.
- Transfer D with `ir_in`=16'h01A5 (IMMW=9), then `wr_en`, `wr_sel`=3, then transfer R3 → `bus_out`=16'h01A5 both times. Repeat with DS on `ir_in`=16'h0180 → 16'hFF80, and with DT on `ir_in`=16'h00C3 → 16'hC300.
- Load R1=16'h1234 and transfer G with `g_in`=16'hBEEF. In the same cycle the bus loads G, issue `wr_en` to R1 → R1=16'h1234; next transfer R1 → 16'h1234. Then request R1 in the same cycle as writing R1 with `bus_out`=16'hBEEF → bus loads 16'hBEEF.
- Request `src_sel`=13 (NREGS=8) while `bus_out`=16'h5555 → `bus_out` holds 16'h5555, `bus_valid`=0, `sel_err`=1. Assert `err_clr` alone → `sel_err`=0. Assert an invalid request together with `err_clr` → `sel_err` stays 1.
- Assert `rst` during a transfer cycle with R2 holding 16'hAAAA → after release, transfer R2 → `bus_out`=0.
- Rerun with WIDTH=32, NREGS=5, IMMW=12: D on 32'h00000FFF → 32'h00000FFF, DS → 32'hFFFFFFFF, `wr_sel`=6 is ignored, code 9 (NREGS+4) sets `sel_err`.
